// File: rtl/avalon_arbiter_pkg.sv
// rtl/avalon_arbiter_pkg.sv - shared Avalon interconnect types and defaults
//
// Purpose: arbiter state encoding, default burst-count width and the
// round-robin index helper shared by the arbiter and its picker.
// Ports: none (package).
package avalon_arbiter_pkg;

    localparam int AV_BURST_WIDTH = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index visited 'offset' steps after 'base' in an n-entry ring.
    function automatic int rr_next(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/avalon_arbiter_rr_picker.sv
// rtl/avalon_arbiter_rr_picker.sv - combinational round-robin priority pick
//
// Purpose: picks the first requester after the pointer, wrapping around the
// ring, so the pointer itself has the lowest priority.
// Ports:
//   i_Req     request vector, one bit per master
//   i_Ptr     index of the last granted master
//   o_OneHot  one-hot winner (zero when no request)
//   o_Index   binary winner index (zero when no request)
//   o_Valid   at least one request present
module avalon_arbiter_rr_picker
    import avalon_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int SEL_WIDTH  = 1
) (
    input  logic [NUM_INPUTS-1:0] i_Req,
    input  logic [SEL_WIDTH-1:0]  i_Ptr,
    output logic [NUM_INPUTS-1:0] o_OneHot,
    output logic [SEL_WIDTH-1:0]  o_Index,
    output logic                  o_Valid
);

    logic found;

    always_comb begin
        o_OneHot = '0;
        o_Index  = '0;
        found    = 1'b0;
        // Offsets 1..N visit ptr+1 first and ptr itself last.
        for (int i = 1; i <= NUM_INPUTS; i++) begin
            if (!found && i_Req[rr_next(int'(i_Ptr), i, NUM_INPUTS)]) begin
                found = 1'b1;
                o_OneHot[rr_next(int'(i_Ptr), i, NUM_INPUTS)] = 1'b1;
                o_Index = SEL_WIDTH'(rr_next(int'(i_Ptr), i, NUM_INPUTS));
            end
        end
        o_Valid = found;
    end

endmodule

// File: rtl/avalon_arbiter.sv
// rtl/avalon_arbiter.sv - burst-locking round-robin arbiter for Avalon masters
//
// Purpose: grants one master at a time, holds the grant for the full burst
// (counted in accepted beats), and gates the other masters off the mux.
// Ports:
//   i_Clk, i_Rst_n        clock, asynchronous active-low reset
//   i_AVIn_Read/Write     per-master requests
//   i_AVIn_BurstCount     per-master burst length, master k at [k*BW +: BW]
//   o_AVIn_WaitRequest    wait back to masters (forced high unless granted)
//   o_AVMux_Read/Write    requests gated by grant, to the mux
//   i_AVMux_WaitRequest   per-input wait from the mux
//   o_MuxSel              index of current/last granted master
//   o_Grant               registered one-hot grant, zero when idle
//   o_Busy                high while a burst is locked
module avalon_arbiter
    import avalon_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter int SEL_WIDTH   = 1,
    parameter int BURST_WIDTH = AV_BURST_WIDTH
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst_n,
    input  logic [NUM_INPUTS-1:0]             i_AVIn_Read,
    input  logic [NUM_INPUTS-1:0]             i_AVIn_Write,
    input  logic [NUM_INPUTS*BURST_WIDTH-1:0] i_AVIn_BurstCount,
    output logic [NUM_INPUTS-1:0]             o_AVIn_WaitRequest,
    output logic [NUM_INPUTS-1:0]             o_AVMux_Read,
    output logic [NUM_INPUTS-1:0]             o_AVMux_Write,
    input  logic [NUM_INPUTS-1:0]             i_AVMux_WaitRequest,
    output logic [SEL_WIDTH-1:0]              o_MuxSel,
    output logic [NUM_INPUTS-1:0]             o_Grant,
    output logic                              o_Busy
);

    arb_state_e              state_q, state_d;
    logic [NUM_INPUTS-1:0]   grant_q, grant_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
    logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;

    logic [NUM_INPUTS-1:0]   req;
    logic [NUM_INPUTS-1:0]   pick_onehot;
    logic [SEL_WIDTH-1:0]    pick_index;
    logic                    pick_valid;
    logic [BURST_WIDTH-1:0]  winner_bc;
    logic                    beat;

    assign req = i_AVIn_Read | i_AVIn_Write;

    avalon_arbiter_rr_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_picker (
        .i_Req    (req),
        .i_Ptr    (ptr_q),
        .o_OneHot (pick_onehot),
        .o_Index  (pick_index),
        .o_Valid  (pick_valid)
    );

    // Gating uses the registered grant, so an asynchronous reset clearing
    // grant_q drops the mux requests immediately without a clock edge.
    assign o_AVMux_Read       = i_AVIn_Read & grant_q;
    assign o_AVMux_Write      = i_AVIn_Write & grant_q;
    assign o_AVIn_WaitRequest = i_AVMux_WaitRequest | ~grant_q;
    assign o_Grant            = grant_q;
    assign o_MuxSel           = sel_q;
    assign o_Busy             = (state_q == ARB_LOCKED);

    // Read and write together on the granted port still make one beat.
    assign beat = (state_q == ARB_LOCKED) &&
                  (|((o_AVMux_Read | o_AVMux_Write) & grant_q & ~i_AVMux_WaitRequest));

    always_comb begin
        winner_bc = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (pick_onehot[k]) begin
                winner_bc = i_AVIn_BurstCount[k*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_LOCKED;
                    grant_d = pick_onehot;
                    sel_d   = pick_index;
                    ptr_d   = pick_index;
                    // A zero burst count is treated as a single-beat burst.
                    cnt_d   = (winner_bc == '0) ? BURST_WIDTH'(1) : winner_bc;
                end
            end
            ARB_LOCKED: begin
                if (beat) begin
                    if (cnt_q == BURST_WIDTH'(1)) begin
                        // Last beat: release; o_MuxSel keeps the old index.
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - BURST_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            // Pointer at the last master so master 0 is searched first.
            ptr_q   <= SEL_WIDTH'(NUM_INPUTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_avalon_arbiter.sv
// tb/tb_avalon_arbiter.sv - self-checking bench for avalon_arbiter
module tb_avalon_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  av_read;
    logic [1:0]  av_write;
    logic [15:0] av_bc;
    logic [1:0]  av_wait;
    logic [1:0]  mux_read;
    logic [1:0]  mux_write;
    logic [1:0]  mux_wait;
    logic [0:0]  mux_sel;
    logic [1:0]  grant;
    logic        busy;

    avalon_arbiter #(
        .NUM_INPUTS  (2),
        .SEL_WIDTH   (1),
        .BURST_WIDTH (8)
    ) dut (
        .i_Clk               (clk),
        .i_Rst_n             (rst_n),
        .i_AVIn_Read         (av_read),
        .i_AVIn_Write        (av_write),
        .i_AVIn_BurstCount   (av_bc),
        .o_AVIn_WaitRequest  (av_wait),
        .o_AVMux_Read        (mux_read),
        .o_AVMux_Write       (mux_write),
        .i_AVMux_WaitRequest (mux_wait),
        .o_MuxSel            (mux_sel),
        .o_Grant             (grant),
        .o_Busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {grant, sel, busy, av_wait, mux_read, mux_write}.
    typedef struct packed {
        logic       rst;
        logic [1:0] rd;
        logic [1:0] wr;
        logic [7:0] bc0;
        logic [7:0] bc1;
        logic [1:0] mwait;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    vec_t vecs[30];
    sb_t  sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic r, input logic [1:0] rd, input logic [1:0] wr,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] mw_in,
                                input logic [1:0] g, input logic s, input logic b,
                                input logic [1:0] w, input logic [1:0] mr, input logic [1:0] mw);
        vec_t v;
        v.rst   = r;
        v.rd    = rd;
        v.wr    = wr;
        v.bc0   = b0;
        v.bc1   = b1;
        v.mwait = mw_in;
        v.exp   = {g, s, b, w, mr, mw};
        return v;
    endfunction

    function automatic logic [9:0] observed();
        return {grant, mux_sel, busy, av_wait, mux_read, mux_write};
    endfunction

    task automatic expect_push(input string name, input logic [9:0] e);
        sb_t item;
        item.name = name;
        item.exp  = e;
        sb_q.push_back(item);
    endtask

    task automatic check_pop();
        sb_t        item;
        logic [9:0] act;
        item = sb_q.pop_front();
        act  = observed();
        n_vec++;
        if (act !== item.exp) begin
            n_miss++;
            $display("FAIL %s: got g=%b sel=%b busy=%b wait=%b mrd=%b mwr=%b, want g=%b sel=%b busy=%b wait=%b mrd=%b mwr=%b",
                     item.name, act[9:8], act[7], act[6], act[5:4], act[3:2], act[1:0],
                     item.exp[9:8], item.exp[7], item.exp[6], item.exp[5:4], item.exp[3:2], item.exp[1:0]);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        av_read  = '0;
        av_write = '0;
        av_bc    = '0;
        mux_wait = '0;

        //               rst  rd     wr     bc0  bc1  mwait  grant  s     b     wait   mrd    mwr
        // Reset, idle, single-beat write with one slave wait cycle.
        vecs[0]  = mk(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[1]  = mk(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[2]  = mk(1'b0, 2'b00, 2'b01, 8'd1, 8'd0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[3]  = mk(1'b0, 2'b00, 2'b01, 8'd1, 8'd0, 2'b01, 2'b01, 1'b0, 1'b1, 2'b11, 2'b00, 2'b01);
        vecs[4]  = mk(1'b0, 2'b00, 2'b01, 8'd1, 8'd0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01);
        vecs[5]  = mk(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        // Simultaneous M0 write / M1 read, then M1 4-beat burst with stalls.
        vecs[6]  = mk(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[7]  = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[8]  = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd1, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01);
        vecs[9]  = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[10] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd1, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b10, 2'b00);
        vecs[11] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[12] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01);
        vecs[13] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[14] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b10, 2'b10, 1'b1, 1'b1, 2'b11, 2'b10, 2'b00);
        vecs[15] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b10, 2'b00);
        vecs[16] = mk(1'b0, 2'b00, 2'b01, 8'd1, 8'd4, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
        vecs[17] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b10, 2'b00);
        vecs[18] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b10, 2'b00);
        vecs[19] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 2'b10, 2'b00);
        vecs[20] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[21] = mk(1'b0, 2'b10, 2'b01, 8'd1, 8'd4, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01);
        // Burst count 0 behaves as 1; read+write together is a single beat.
        vecs[22] = mk(1'b1, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[23] = mk(1'b0, 2'b00, 2'b01, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[24] = mk(1'b0, 2'b00, 2'b01, 8'd0, 8'd0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01);
        vecs[25] = mk(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[26] = mk(1'b0, 2'b01, 2'b01, 8'd2, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
        vecs[27] = mk(1'b0, 2'b01, 2'b01, 8'd2, 8'd0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b01, 2'b01);
        vecs[28] = mk(1'b0, 2'b01, 2'b01, 8'd2, 8'd0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2'b01, 2'b01);
        vecs[29] = mk(1'b0, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rst_n    = !vecs[i].rst;
            av_read  = vecs[i].rd;
            av_write = vecs[i].wr;
            av_bc    = {vecs[i].bc1, vecs[i].bc0};
            mux_wait = vecs[i].mwait;
            expect_push($sformatf("vec%0d", i), vecs[i].exp);
            #1;
            check_pop();
        end

        // Asynchronous reset two beats into a four-beat M0 burst.
        @(negedge clk);
        rst_n    = 1'b0;
        av_read  = 2'b00;
        av_write = 2'b00;
        mux_wait = 2'b00;
        @(negedge clk);
        rst_n    = 1'b1;
        av_read  = 2'b10;
        av_write = 2'b01;
        av_bc    = {8'd4, 8'd4};
        @(negedge clk);          // granted to M0 after this cycle's edge
        @(negedge clk);          // beat 1 taken at the previous edge
        @(negedge clk);          // beat 2 taken
        #1;
        expect_push("mid_burst", {2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01});
        check_pop();
        #2;
        rst_n = 1'b0;
        #1;
        expect_push("async_abort", {2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00});
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int budget;
            budget = 0;
            while (grant == 2'b00 && budget < 4) begin
                @(negedge clk);
                budget++;
            end
            #1;
            n_vec++;
            if (grant == 2'b00) begin
                n_miss++;
                $display("FAIL regrant_timeout: got grant=%b after %0d cycles, want a grant", grant, budget);
            end
        end
        expect_push("post_reset_m0_first", {2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01});
        check_pop();

        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
